alu_dec_queue: RTL and testbench

//  Multi-lane ALU decode stage with a buffered ready/valid output. Each cycle it accepts up to

---
 rtl/alu_dec_queue.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_alu_dec_queue.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dec_queue.sv
// alu_dec_queue: multi-lane ALU decode stage feeding a Depth-entry ready/valid FIFO.
// Latency: a bundle pushed in cycle N is visible at the output in cycle N+1 (no pass-through).
// Backpressure: in_ready_o drops when the FIFO is full; a pop frees its slot only on the next cycle.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   cheri_pmode_i            CHERI pure-capability mode, sampled with each push
//   flush_i                  synchronous discard of every entry (wins over push/pop)
//   in_valid_i/in_ready_o    input bundle handshake
//   in_lane_vld_i            per-lane valid, stored verbatim
//   in_instr_i               NLanes packed ir_dec_t {insn, is_comp, cheri_op}
//   out_valid_o/out_ready_i  head entry handshake
//   out_lane_vld_o, out_imm_o, out_alu_op_o, out_op_a_sel_o, out_op_b_sel_o, out_illegal_o
//                            head payload, forced to 0 while the FIFO is empty
//   count_o                  occupancy
//
// Optional feature: define ALU_DEC_ILLEGAL_EN to flag unsupported OP/OP_IMM encodings on
// out_illegal_o (flag stored with the entry). Without it out_illegal_o is tied to 0.

package alu_dec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SRA  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_A_REG_A  = 2'd0,
    OP_A_FWD    = 2'd1,
    OP_A_CURRPC = 2'd2,
    OP_A_IMM    = 2'd3
  } op_a_sel_e;

  typedef enum logic {
    OP_B_REG_B = 1'b0,
    OP_B_IMM   = 1'b1
  } op_b_sel_e;

  // cheri_op one-hot bits: [0] cincaddr, [1] cincaddrimm, [2] csub
  typedef struct packed {
    logic [31:0] insn;
    logic        is_comp;
    logic [2:0]  cheri_op;
  } ir_dec_t;

  localparam int IrW     = $bits(ir_dec_t);
  localparam int AluOpW  = $bits(alu_op_e);
  localparam int OpASelW = $bits(op_a_sel_e);

  localparam int CheriIncAddr    = 0;
  localparam int CheriIncAddrImm = 1;
  localparam int CheriSub        = 2;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_CHERI  = 7'h5b;
  localparam logic [6:0] OPC_AUICGP = 7'h7b;

endpackage

module alu_dec_queue
  import alu_dec_pkg::*;
#(
  parameter logic CHERIoTEn = 1'b1,
  parameter int   NLanes    = 2,
  parameter int   Depth     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cheri_pmode_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NLanes-1:0]            in_lane_vld_i,
  input  logic [NLanes*IrW-1:0]        in_instr_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NLanes-1:0]            out_lane_vld_o,
  output logic [32*NLanes-1:0]         out_imm_o,
  output logic [AluOpW*NLanes-1:0]     out_alu_op_o,
  output logic [OpASelW*NLanes-1:0]    out_op_a_sel_o,
  output logic [NLanes-1:0]            out_op_b_sel_o,
  output logic [NLanes-1:0]            out_illegal_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth+1);

  // ---------------------------------------------------------------------------
  // Per-lane combinational decode
  // ---------------------------------------------------------------------------
  logic [32*NLanes-1:0]      dec_imm;
  logic [AluOpW*NLanes-1:0]  dec_op;
  logic [OpASelW*NLanes-1:0] dec_a_sel;
  logic [NLanes-1:0]         dec_b_sel;
  logic [NLanes-1:0]         dec_ill;

  for (genvar g = 0; g < NLanes; g++) begin : g_lane
    ir_dec_t     ir;
    logic [31:0] insn;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_c;
    alu_op_e     op;
    op_a_sel_e   a_sel;
    op_b_sel_e   b_sel;
    logic [31:0] imm;
    logic        ill;
    logic        unused_fields;

    assign ir    = ir_dec_t'(in_instr_i[g*IrW +: IrW]);
    assign insn  = ir.insn;
    assign f3    = insn[14:12];
    assign f7    = insn[31:25];
    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_u = {insn[31:12], 12'h000};
    // CHERIoT 20-bit immediate is scaled by 2^11 rather than 2^12
    assign imm_c = {insn[31], insn[31:12], 11'h000};

    // Register specifiers are consumed further down the pipe; cincaddrimm is the
    // fall-through case of the CHERI op_b selection.
    assign unused_fields = ^{insn[19:15], insn[11:7], ir.cheri_op[CheriIncAddrImm]};

    always_comb begin
      op    = ALU_SLTU;
      a_sel = OP_A_IMM;
      b_sel = OP_B_IMM;
      imm   = imm_i;
      ill   = 1'b0;
      case (insn[6:0])
        OPC_JAL, OPC_JALR: begin
          a_sel = OP_A_CURRPC;
          b_sel = OP_B_IMM;
          op    = ALU_ADD;
          imm   = ir.is_comp ? 32'd2 : 32'd4;
        end
        OPC_LUI: begin
          a_sel = OP_A_IMM;
          b_sel = OP_B_IMM;
          op    = ALU_ADD;
          imm   = imm_u;
        end
        OPC_AUIPC: begin
          a_sel = OP_A_CURRPC;
          b_sel = OP_B_IMM;
          op    = ALU_ADD;
          imm   = (CHERIoTEn && cheri_pmode_i) ? imm_c : imm_u;
        end
        OPC_OP_IMM: begin
          a_sel = OP_A_REG_A;
          b_sel = OP_B_IMM;
          case (f3)
            3'b000: op = ALU_ADD;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            3'b001: begin
              op  = ALU_SLL;
              ill = |insn[31:25];
            end
            3'b101: begin
              if (insn[31:27] == 5'b00000) begin
                op = ALU_SRL;
              end else if (insn[31:27] == 5'b01000) begin
                op = ALU_SRA;
              end else begin
                ill = 1'b1;
              end
            end
            default: ;
          endcase
        end
        OPC_OP: begin
          a_sel = OP_A_REG_A;
          b_sel = OP_B_REG_B;
          case ({f7, f3})
            {7'b0000000, 3'b000}: op = ALU_ADD;
            {7'b0100000, 3'b000}: op = ALU_SUB;
            {7'b0000000, 3'b010}: op = ALU_SLT;
            {7'b0000000, 3'b011}: op = ALU_SLTU;
            {7'b0000000, 3'b100}: op = ALU_XOR;
            {7'b0000000, 3'b110}: op = ALU_OR;
            {7'b0000000, 3'b111}: op = ALU_AND;
            {7'b0000000, 3'b001}: op = ALU_SLL;
            {7'b0000000, 3'b101}: op = ALU_SRL;
            {7'b0100000, 3'b101}: op = ALU_SRA;
            default:              ill = 1'b1;
          endcase
        end
        OPC_CHERI: begin
          if (CHERIoTEn) begin
            a_sel = OP_A_REG_A;
            op    = ir.cheri_op[CheriSub] ? ALU_SUB : ALU_ADD;
            b_sel = (ir.cheri_op[CheriIncAddr] || ir.cheri_op[CheriSub]) ? OP_B_REG_B : OP_B_IMM;
          end
        end
        OPC_AUICGP: begin
          if (CHERIoTEn) begin
            a_sel = OP_A_REG_A;
            b_sel = OP_B_IMM;
            op    = ALU_ADD;
            imm   = imm_c;
          end
        end
        default: ;
      endcase
    end

    assign dec_imm[g*32 +: 32]            = imm;
    assign dec_op[g*AluOpW +: AluOpW]     = op;
    assign dec_a_sel[g*OpASelW +: OpASelW] = a_sel;
    assign dec_b_sel[g]                   = b_sel;
    assign dec_ill[g]                     = ill;
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q,  count_d;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready_o  = (count_q != CntW'(Depth));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage (not reset; payload is gated while empty)
  // ---------------------------------------------------------------------------
  logic [NLanes-1:0]         mem_vld_q   [Depth];
  logic [32*NLanes-1:0]      mem_imm_q   [Depth];
  logic [AluOpW*NLanes-1:0]  mem_op_q    [Depth];
  logic [OpASelW*NLanes-1:0] mem_a_sel_q [Depth];
  logic [NLanes-1:0]         mem_b_sel_q [Depth];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_vld_q[wr_ptr_q]   <= in_lane_vld_i;
      mem_imm_q[wr_ptr_q]   <= dec_imm;
      mem_op_q[wr_ptr_q]    <= dec_op;
      mem_a_sel_q[wr_ptr_q] <= dec_a_sel;
      mem_b_sel_q[wr_ptr_q] <= dec_b_sel;
    end
  end

  assign out_lane_vld_o = out_valid_o ? mem_vld_q[rd_ptr_q]   : '0;
  assign out_imm_o      = out_valid_o ? mem_imm_q[rd_ptr_q]   : '0;
  assign out_alu_op_o   = out_valid_o ? mem_op_q[rd_ptr_q]    : '0;
  assign out_op_a_sel_o = out_valid_o ? mem_a_sel_q[rd_ptr_q] : '0;
  assign out_op_b_sel_o = out_valid_o ? mem_b_sel_q[rd_ptr_q] : '0;

`ifdef ALU_DEC_ILLEGAL_EN
  logic [NLanes-1:0] mem_ill_q [Depth];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ill_q[wr_ptr_q] <= dec_ill;
    end
  end

  assign out_illegal_o = out_valid_o ? mem_ill_q[rd_ptr_q] : '0;
`else
  logic unused_dec_ill;

  assign unused_dec_ill = ^dec_ill;
  assign out_illegal_o  = '0;
`endif

endmodule

// File: tb/tb_alu_dec_queue.sv
// Self-checking bench for alu_dec_queue (NLanes=2, Depth=4).
// Expected decode results are hand-written constants pushed to a scoreboard queue
// as each bundle is driven, and popped/compared as the head entry is consumed.
module tb_alu_dec_queue;
  import alu_dec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pmode;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_lane_vld;
  logic [71:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane_vld;
  logic [63:0] out_imm;
  logic [7:0]  out_alu_op;
  logic [3:0]  out_op_a_sel;
  logic [1:0]  out_op_b_sel;
  logic [1:0]  out_illegal;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]  vld;
    logic [63:0] imm;
    logic [7:0]  op;
    logic [3:0]  a;
    logic [1:0]  b;
    logic [1:0]  ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_dec_queue dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cheri_pmode_i  (pmode),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_lane_vld_i  (in_lane_vld),
    .in_instr_i     (in_instr),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_lane_vld_o (out_lane_vld),
    .out_imm_o      (out_imm),
    .out_alu_op_o   (out_alu_op),
    .out_op_a_sel_o (out_op_a_sel),
    .out_op_b_sel_o (out_op_b_sel),
    .out_illegal_o  (out_illegal),
    .count_o        (count)
  );

  function automatic logic [35:0] ir(input logic [31:0] insn, input logic c, input logic [2:0] cop);
    return {insn, c, cop};
  endfunction

  function automatic logic [31:0] addi(input logic [11:0] k);
    return {k, 5'd2, 3'b000, 5'd1, 7'h13};
  endfunction

  function automatic exp_t mk(input logic [1:0] vld,
                              input logic [31:0] i0, input logic [3:0] o0, input logic [1:0] a0,
                              input logic b0, input logic l0,
                              input logic [31:0] i1, input logic [3:0] o1, input logic [1:0] a1,
                              input logic b1, input logic l1);
    exp_t e;
    e.vld = vld;
    e.imm = {i1, i0};
    e.op  = {o1, o0};
    e.a   = {a1, a0};
    e.b   = {b1, b0};
    e.ill = {l1, l0};
    return e;
  endfunction

  // Drive one bundle on the next falling edge; it is accepted on the following rising edge.
  task automatic push_b(input logic [1:0] vld, input logic [35:0] l0, input logic [35:0] l1,
                        input logic pm, input exp_t e, input logic track);
    @(negedge clk);
    in_valid    = 1'b1;
    in_lane_vld = vld;
    in_instr    = {l1, l0};
    pmode       = pm;
    if (track) sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pmode = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lane_vld = '0; in_instr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: count=%0d valid=%b ready=%b, need count=0 valid=0 ready=1",
               count, out_valid, in_ready);
    end
    n_cmp++;
    if (out_imm !== 64'd0 || out_lane_vld !== 2'b00 || out_alu_op !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_gated_payload: imm=%h vld=%b op=%h, need all 0", out_imm, out_lane_vld, out_alu_op);
    end
  endtask

  task automatic test_decode();
    exp_t        e;
    int          t;
    logic [39:0] got;
    logic [39:0] need;
    logic [1:0]  eill;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        push_b(2'b11, ir(32'hFFF10093, 1'b0, 3'b000), ir(32'h00001017, 1'b0, 3'b000), 1'b0,
               mk(2'b11, 32'hFFFFFFFF, ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0,
                         32'h00001000, ALU_ADD, OP_A_CURRPC, OP_B_IMM, 1'b0), 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL no_passthrough: valid=%b, need 0", out_valid);
        end
        push_b(2'b11, ir(32'h40000033, 1'b0, 3'b000), ir(32'h00001017, 1'b0, 3'b000), 1'b1,
               mk(2'b11, 32'h00000400, ALU_SUB, OP_A_REG_A, OP_B_REG_B, 1'b0,
                         32'h00000800, ALU_ADD, OP_A_CURRPC, OP_B_IMM, 1'b0), 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || count !== 3'd1) begin
          n_bad++;
          $display("FAIL latency_1cycle: valid=%b count=%0d, need valid=1 count=1", out_valid, count);
        end
        push_b(2'b11, ir(32'h02000033, 1'b0, 3'b000), ir(32'h0040006F, 1'b1, 3'b000), 1'b0,
               mk(2'b11, 32'h00000020, ALU_SLTU, OP_A_REG_A, OP_B_REG_B, 1'b1,
                         32'h00000002, ALU_ADD, OP_A_CURRPC, OP_B_IMM, 1'b0), 1'b1);
      end else begin
        push_b(2'b11, ir(32'h12345037, 1'b0, 3'b000), ir(32'h40315093, 1'b0, 3'b000), 1'b0,
               mk(2'b11, 32'h12345000, ALU_ADD, OP_A_IMM, OP_B_IMM, 1'b0,
                         32'h00000403, ALU_SRA, OP_A_REG_A, OP_B_IMM, 1'b0), 1'b1);
        push_b(2'b11, ir(32'h0000005B, 1'b0, 3'b001), ir(32'hFFFFF07B, 1'b0, 3'b000), 1'b0,
               mk(2'b11, 32'h00000000, ALU_ADD, OP_A_REG_A, OP_B_REG_B, 1'b0,
                         32'hFFFFF800, ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0), 1'b1);
        push_b(2'b11, ir(32'h60315093, 1'b0, 3'b000), ir(32'h0020C0B3, 1'b0, 3'b000), 1'b0,
               mk(2'b11, 32'h00000603, ALU_SLTU, OP_A_REG_A, OP_B_IMM, 1'b1,
                         32'h00000002, ALU_XOR, OP_A_REG_A, OP_B_REG_B, 1'b0), 1'b1);
        push_b(2'b11, ir(32'h02109093, 1'b0, 3'b000), ir(32'h0000005B, 1'b0, 3'b100), 1'b0,
               mk(2'b11, 32'h00000021, ALU_SLL, OP_A_REG_A, OP_B_IMM, 1'b1,
                         32'h00000000, ALU_SUB, OP_A_REG_A, OP_B_REG_B, 1'b0), 1'b1);
      end
      idle();
      out_ready = 1'b1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        t = 0;
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        n_cmp++;
        if (out_valid !== 1'b1 || out_lane_vld !== e.vld) begin
          n_bad++;
          $display("FAIL decode_head r%0d: valid=%b vld=%b, need valid=1 vld=%b", r, out_valid, out_lane_vld, e.vld);
        end
`ifdef ALU_DEC_ILLEGAL_EN
        eill = e.ill;
`else
        eill = 2'b00;
`endif
        for (int l = 0; l < 2; l++) begin
          if (e.vld[l]) begin
            got  = {out_imm[l*32 +: 32], out_alu_op[l*4 +: 4], out_op_a_sel[l*2 +: 2], out_op_b_sel[l], out_illegal[l]};
            need = {e.imm[l*32 +: 32], e.op[l*4 +: 4], e.a[l*2 +: 2], e.b[l], eill[l]};
            n_cmp++;
            if (got !== need) begin
              n_bad++;
              $display("FAIL decode_lane%0d r%0d: {imm,op,a,b,ill} got %h need %h", l, r, got, need);
            end
          end
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push_b(2'b11, ir(addi(12'h011), 1'b0, 3'b000), ir(addi(12'h111), 1'b0, 3'b000), 1'b0,
           mk(2'b11, 32'h11, ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0,
                     32'h111, ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0), 1'b1);
    push_b(2'b11, ir(addi(12'h022), 1'b0, 3'b000), ir(addi(12'h122), 1'b0, 3'b000), 1'b0,
           mk(2'b11, 32'h22, ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0,
                     32'h122, ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0), 1'b1);
    out_ready = 1'b1;
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== e.imm) begin
      n_bad++;
      $display("FAIL b2b_first_head: valid=%b imm=%h, need valid=1 imm=%h", out_valid, out_imm, e.imm);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (count !== 3'd1 || out_imm !== e.imm) begin
      n_bad++;
      $display("FAIL b2b_push_pop: count=%0d imm=%h, need count=1 imm=%h", count, out_imm, e.imm);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_imm !== 64'd0) begin
      n_bad++;
      $display("FAIL empty_gated: count=%0d valid=%b imm=%h, need 0 0 0", count, out_valid, out_imm);
    end
    // Consumer ready on an empty FIFO must not underflow.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_pop: count=%0d valid=%b, need count=0 valid=0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      push_b(2'b11, ir(addi(12'(k)), 1'b0, 3'b000), ir(addi(12'(k)), 1'b0, 3'b000), 1'b0, '0, 1'b0);
    end
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd3) begin
      n_bad++;
      $display("FAIL flush_precount: count=%0d, need 3", count);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush: count=%0d valid=%b ready=%b, need 0 0 1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_full();
    exp_t        e;
    int          t;
    logic [39:0] got;
    logic [39:0] need;
    logic [1:0]  pat [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    for (int k = 1; k <= 4; k++) begin
      push_b(pat[k-1], ir(addi(12'(k)), 1'b0, 3'b000), ir(addi(12'(k+16)), 1'b0, 3'b000), 1'b0,
             mk(pat[k-1], 32'(k), ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0,
                          32'(k+16), ALU_ADD, OP_A_REG_A, OP_B_IMM, 1'b0), 1'b1);
    end
    // A fifth bundle is offered while full; it must be held off.
    push_b(2'b11, ir(addi(12'h7AA), 1'b0, 3'b000), ir(addi(12'h7AA), 1'b0, 3'b000), 1'b0, '0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_ready: ready=%b count=%0d, need ready=0 count=4", in_ready, count);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (count !== 3'd4) begin
      n_bad++;
      $display("FAIL full_hold: count=%0d, need 4", count);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      t = 0;
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      n_cmp++;
      if (out_valid !== 1'b1 || out_lane_vld !== e.vld) begin
        n_bad++;
        $display("FAIL full_order_vld: valid=%b vld=%b, need valid=1 vld=%b", out_valid, out_lane_vld, e.vld);
      end
      for (int l = 0; l < 2; l++) begin
        if (e.vld[l]) begin
          got  = {out_imm[l*32 +: 32], out_alu_op[l*4 +: 4], out_op_a_sel[l*2 +: 2], out_op_b_sel[l], out_illegal[l]};
          need = {e.imm[l*32 +: 32], e.op[l*4 +: 4], e.a[l*2 +: 2], e.b[l], 1'b0};
          n_cmp++;
          if (got !== need) begin
            n_bad++;
            $display("FAIL full_order_lane%0d: got %h need %h", l, got, need);
          end
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL full_drained: count=%0d valid=%b, need 0 0", count, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    push_b(2'b11, ir(addi(12'h5), 1'b0, 3'b000), ir(addi(12'h6), 1'b0, 3'b000), 1'b0, '0, 1'b0);
    push_b(2'b11, ir(addi(12'h7), 1'b0, 3'b000), ir(addi(12'h8), 1'b0, 3'b000), 1'b0, '0, 1'b0);
    idle();
    n_cmp++;
    if (count !== 3'd2) begin
      n_bad++;
      $display("FAIL rst_mid_precount: count=%0d, need 2", count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_async: count=%0d valid=%b ready=%b, need 0 0 1", count, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: count=%0d valid=%b, need 0 0", count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
